// File: rtl/inport_conditioner_pkg.sv
// Shared definitions for the inport conditioner: stop FSM encoding and
// the default debounce length.
package inport_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } stop_state_t;

endpackage

// File: rtl/inport_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; width-parameterized
// so one module serves both the switch bus and the stop button.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two back-to-back flops to settle metastability before any use.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign q = sync2;

endmodule

// File: rtl/inport_conditioner.sv
// Debounces the board switch bus into the datapath inport word and the stop
// pushbutton into a level plus a one-cycle press pulse.
//
// Stop FSM states:
//   state      | meaning
//   IDLE       | button released, stop = 0
//   PRESS_WAIT | input high, counting stable cycles before accepting the press
//   HELD       | press accepted, stop = 1
//   REL_WAIT   | input low, counting stable cycles before accepting release
module inport_conditioner
    import inport_conditioner_pkg::*;
#(
    parameter int REG_SIZE        = 32,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_SIZE-1:0] sw_raw,
    input  logic                stop_raw,
    output logic [REG_SIZE-1:0] inport_ext_input,
    output logic                sw_changed,
    output logic                stop,
    output logic                stop_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [REG_SIZE-1:0] sw_sync;
    logic                stop_sync;

    logic [REG_SIZE-1:0] sw_cand;
    logic [CNT_W-1:0]    sw_cnt;

    stop_state_t         state;
    stop_state_t         state_nxt;
    logic [CNT_W-1:0]    stop_cnt;
    logic [CNT_W-1:0]    stop_cnt_nxt;
    logic                stop_nxt;
    logic                stop_pulse_nxt;

    sync_2ff #(.WIDTH(REG_SIZE)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_sync)
    );

    sync_2ff #(.WIDTH(1)) u_sync_stop (
        .clk   (clk),
        .reset (reset),
        .d     (stop_raw),
        .q     (stop_sync)
    );

    // Switch word qualification: any bit change restarts the count, and the
    // whole word is accepted only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_cand          <= '0;
            sw_cnt           <= '0;
            inport_ext_input <= '0;
            sw_changed       <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                sw_cnt  <= '0;
            end else if (sw_cnt != CNT_MAX) begin
                sw_cnt <= sw_cnt + CNT_ONE;
            end else begin
                // Saturated: keep reloading the same word, flag only real changes.
                inport_ext_input <= sw_cand;
                sw_changed       <= (sw_cand != inport_ext_input);
            end
        end
    end

    // Stop FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stop_cnt   <= '0;
            stop       <= 1'b0;
            stop_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            stop_cnt   <= stop_cnt_nxt;
            stop       <= stop_nxt;
            stop_pulse <= stop_pulse_nxt;
        end
    end

    // Stop FSM next state; the pulse fires only on an accepted press, not when
    // a release bounce drops back from REL_WAIT into HELD.
    always_comb begin
        state_nxt      = state;
        stop_cnt_nxt   = stop_cnt;
        stop_pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (stop_sync) begin
                    state_nxt    = PRESS_WAIT;
                    stop_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!stop_sync) begin
                    state_nxt = IDLE;
                end else if (stop_cnt == CNT_MAX) begin
                    state_nxt      = HELD;
                    stop_pulse_nxt = 1'b1;
                end else begin
                    stop_cnt_nxt = stop_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!stop_sync) begin
                    state_nxt    = REL_WAIT;
                    stop_cnt_nxt = '0;
                end
            end
            REL_WAIT: begin
                if (stop_sync) begin
                    state_nxt = HELD;
                end else if (stop_cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    stop_cnt_nxt = stop_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        stop_nxt = (state_nxt == HELD) || (state_nxt == REL_WAIT);
    end

endmodule

// File: tb/tb_inport_conditioner.sv
// Self-checking bench for inport_conditioner with DEBOUNCE_CYCLES = 4.
module tb_inport_conditioner;

    localparam int REG_SIZE = 32;
    localparam int DEB      = 4;

    logic                clk;
    logic                reset;
    logic [REG_SIZE-1:0] sw_raw;
    logic                stop_raw;
    logic [REG_SIZE-1:0] inport_ext_input;
    logic                sw_changed;
    logic                stop;
    logic                stop_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [REG_SIZE-1:0] exp_sw[$];
    int                  exp_stop_pulses = 0;

    inport_conditioner #(
        .REG_SIZE        (REG_SIZE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sw_raw           (sw_raw),
        .stop_raw         (stop_raw),
        .inport_ext_input (inport_ext_input),
        .sw_changed       (sw_changed),
        .stop             (stop),
        .stop_pulse       (stop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each sw_changed pulse must match the oldest expected word,
    // and each stop_pulse must consume one expected press.
    always @(negedge clk) begin
        if (sw_changed) begin
            n_checks++;
            if (exp_sw.size() == 0) begin
                n_fail++;
                $display("FAIL sb_sw_unexpected: sw_changed with inport=%h, none expected", inport_ext_input);
            end else begin
                logic [REG_SIZE-1:0] e;
                e = exp_sw.pop_front();
                if (inport_ext_input !== e) begin
                    n_fail++;
                    $display("FAIL sb_sw_value: got %h expected %h", inport_ext_input, e);
                end
            end
        end
        if (stop_pulse) begin
            n_checks++;
            if (exp_stop_pulses == 0) begin
                n_fail++;
                $display("FAIL sb_stop_unexpected: stop_pulse with none expected");
            end else begin
                exp_stop_pulses--;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        sw_raw   = '0;
        stop_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        n_checks += 4;
        if (inport_ext_input !== '0) begin n_fail++; $display("FAIL reset_inport: got %h expected 0", inport_ext_input); end
        if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL reset_sw_changed: got %b expected 0", sw_changed); end
        if (stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b expected 0", stop); end
        if (stop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_stop_pulse: got %b expected 0", stop_pulse); end
    endtask

    task automatic test_clean_change();
        sw_raw = 32'h0000_00A5;
        exp_sw.push_back(32'h0000_00A5);
        tick(6);
        n_checks++;
        if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL clean_early: got %h expected 0", inport_ext_input); end
        tick(1);
        n_checks += 2;
        if (inport_ext_input !== 32'hA5) begin n_fail++; $display("FAIL clean_value: got %h expected a5", inport_ext_input); end
        if (sw_changed !== 1'b1) begin n_fail++; $display("FAIL clean_pulse: got %b expected 1", sw_changed); end
        tick(1);
        n_checks++;
        if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL clean_pulse_width: got %b expected 0", sw_changed); end
        tick(4);
    endtask

    task automatic test_glitch();
        sw_raw = 32'h0;
        exp_sw.push_back(32'h0);
        tick(10);
        n_checks++;
        if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL glitch_setup: got %h expected 0", inport_ext_input); end
        sw_raw = 32'h1;
        tick(3);
        sw_raw = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n_checks++;
            if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL glitch_hold[%0d]: got %h expected 0", i, inport_ext_input); end
        end
    endtask

    task automatic test_glitch_boundary();
        sw_raw = 32'h3C;
        tick(DEB);
        sw_raw = 32'h0;
        tick(12);
        n_checks++;
        if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL glitch_len_d: got %h expected 0", inport_ext_input); end
        sw_raw = 32'h3C;
        exp_sw.push_back(32'h3C);
        exp_sw.push_back(32'h0);
        tick(DEB + 1);
        sw_raw = 32'h0;
        tick(2);
        n_checks++;
        if (inport_ext_input !== 32'h3C) begin n_fail++; $display("FAIL glitch_len_d1: got %h expected 3c", inport_ext_input); end
        tick(10);
        n_checks++;
        if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL glitch_len_d1_back: got %h expected 0", inport_ext_input); end
    endtask

    task automatic test_multibit();
        sw_raw = 32'h01;
        tick(2);
        sw_raw = 32'h03;
        tick(2);
        sw_raw = 32'h07;
        exp_sw.push_back(32'h07);
        tick(6);
        n_checks++;
        if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL multibit_early: got %h expected 0", inport_ext_input); end
        tick(1);
        n_checks++;
        if (inport_ext_input !== 32'h07) begin n_fail++; $display("FAIL multibit_value: got %h expected 07", inport_ext_input); end
        tick(4);
    endtask

    task automatic test_same_value();
        sw_raw = 32'h70;
        tick(2);
        sw_raw = 32'h07;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n_checks++;
            if (inport_ext_input !== 32'h07) begin n_fail++; $display("FAIL same_value[%0d]: got %h expected 07", i, inport_ext_input); end
        end
    endtask

    task automatic test_stop_press();
        stop_raw = 1'b1;
        exp_stop_pulses++;
        tick(6);
        n_checks++;
        if (stop !== 1'b0) begin n_fail++; $display("FAIL stop_early: got %b expected 0", stop); end
        tick(1);
        n_checks += 2;
        if (stop !== 1'b1) begin n_fail++; $display("FAIL stop_rise: got %b expected 1", stop); end
        if (stop_pulse !== 1'b1) begin n_fail++; $display("FAIL stop_pulse: got %b expected 1", stop_pulse); end
        tick(1);
        n_checks++;
        if (stop_pulse !== 1'b0) begin n_fail++; $display("FAIL stop_pulse_width: got %b expected 0", stop_pulse); end
        tick(2);
        stop_raw = 1'b0;
        tick(6);
        n_checks++;
        if (stop !== 1'b1) begin n_fail++; $display("FAIL stop_release_early: got %b expected 1", stop); end
        tick(1);
        n_checks++;
        if (stop !== 1'b0) begin n_fail++; $display("FAIL stop_fall: got %b expected 0", stop); end
        tick(3);
    endtask

    task automatic test_stop_bounce();
        stop_raw = 1'b1; tick(1);
        stop_raw = 1'b0; tick(1);
        stop_raw = 1'b1; tick(1);
        stop_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_checks++;
            if (stop !== 1'b0) begin n_fail++; $display("FAIL stop_bounce[%0d]: got %b expected 0", i, stop); end
        end
    endtask

    task automatic test_reset_in_held();
        stop_raw = 1'b1;
        exp_stop_pulses++;
        tick(7);
        n_checks++;
        if (stop !== 1'b1) begin n_fail++; $display("FAIL held_setup: got %b expected 1", stop); end
        tick(2);
        sw_raw = 32'h0F;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks += 4;
        if (inport_ext_input !== '0) begin n_fail++; $display("FAIL held_reset_inport: got %h expected 0", inport_ext_input); end
        if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL held_reset_sw_changed: got %b expected 0", sw_changed); end
        if (stop !== 1'b0) begin n_fail++; $display("FAIL held_reset_stop: got %b expected 0", stop); end
        if (stop_pulse !== 1'b0) begin n_fail++; $display("FAIL held_reset_stop_pulse: got %b expected 0", stop_pulse); end
        exp_sw.push_back(32'h0F);
        exp_stop_pulses++;
        tick(6);
        n_checks += 2;
        if (inport_ext_input !== 32'h0) begin n_fail++; $display("FAIL requal_early: got %h expected 0", inport_ext_input); end
        if (stop !== 1'b0) begin n_fail++; $display("FAIL restop_early: got %b expected 0", stop); end
        tick(1);
        n_checks += 4;
        if (inport_ext_input !== 32'h0F) begin n_fail++; $display("FAIL requal_value: got %h expected 0f", inport_ext_input); end
        if (sw_changed !== 1'b1) begin n_fail++; $display("FAIL requal_pulse: got %b expected 1", sw_changed); end
        if (stop !== 1'b1) begin n_fail++; $display("FAIL restop_rise: got %b expected 1", stop); end
        if (stop_pulse !== 1'b1) begin n_fail++; $display("FAIL restop_pulse: got %b expected 1", stop_pulse); end
        stop_raw = 1'b0;
        tick(10);
        n_checks++;
        if (stop !== 1'b0) begin n_fail++; $display("FAIL restop_fall: got %b expected 0", stop); end
    endtask

    task automatic test_drain();
        tick(4);
        n_checks += 2;
        if (exp_sw.size() != 0) begin n_fail++; $display("FAIL sb_sw_missing: %0d pulses outstanding, expected 0", exp_sw.size()); end
        if (exp_stop_pulses != 0) begin n_fail++; $display("FAIL sb_stop_missing: %0d pulses outstanding, expected 0", exp_stop_pulses); end
    endtask

    initial begin
        test_reset();
        test_clean_change();
        test_glitch();
        test_glitch_boundary();
        test_multibit();
        test_same_value();
        test_stop_press();
        test_stop_bounce();
        test_reset_in_held();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inport_conditioner.md
INPORT_CONDITIONER -- requirements
Module: inport_conditioner

Interface
REQ-001 SHALL have parameter REG_SIZE, default 32: width of switch bus and conditioned inport word.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles (min 2) before a value is accepted.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset; one clock, reset synchronous, active-high.
REQ-005 SHALL have port sw_raw  input  REG_SIZE  asynchronous board switch levels.
REQ-006 SHALL have port stop_raw  input  1  asynchronous stop pushbutton level, 1 = pressed.
REQ-007 SHALL have port inport_ext_input  output  REG_SIZE  debounced switch word driving the datapath inport.
REQ-008 SHALL have port sw_changed  output  1  one-cycle pulse when inport_ext_input takes a new, different value.
REQ-009 SHALL have port stop  output  1  debounced stop level driving the control unit stop input.
REQ-010 SHALL have port stop_pulse  output  1  one-cycle pulse on accepted press.

Function
REQ-011 SHALL pass sw_raw and stop_raw through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-012 SHALL hold a switch candidate register and a counter saturating at DEBOUNCE_CYCLES-1; counter width SHALL be clog2(DEBOUNCE_CYCLES).
REQ-013 SHALL, when sync2 differs from candidate, load candidate from sync2 and clear counter to 0 on that edge.
REQ-014 SHALL, when sync2 equals candidate and counter < DEBOUNCE_CYCLES-1, increment counter.
REQ-015 SHALL, when sync2 equals candidate and counter == DEBOUNCE_CYCLES-1, load inport_ext_input from candidate; sw_changed SHALL be 1 in the following cycle only if the loaded value differs from the previous output.
REQ-016 SHALL make a clean switch change visible on inport_ext_input after the (DEBOUNCE_CYCLES+3)th rising edge, counting the edge that first samples the new sw_raw.
REQ-017 SHALL restart qualification on any glitch shorter than DEBOUNCE_CYCLES+1 cycles, leaving inport_ext_input unchanged.
REQ-018 SHALL treat multiple bits changing on different cycles as one word; qualification restarts on each bit change.
REQ-019 SHALL run the stop FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT and its own saturating counter.
REQ-020 SHALL move IDLE->PRESS_WAIT (counter cleared) when sync2 stop is 1; otherwise stay in IDLE.
REQ-021 SHALL, in PRESS_WAIT: return to IDLE if sync2 stop is 0; increment counter otherwise; at counter == DEBOUNCE_CYCLES-1 with input 1, go to HELD.
REQ-022 SHALL, on entry to HELD, set stop to 1 and assert stop_pulse for exactly that one cycle.
REQ-023 SHALL, in HELD, move to REL_WAIT (counter cleared) when input is 0.
REQ-024 SHALL, in REL_WAIT: return to HELD if input is 1; go to IDLE at counter == DEBOUNCE_CYCLES-1 with input 0; clear stop on entry to IDLE.
REQ-025 SHALL keep stop at 1 in HELD and REL_WAIT, and at 0 in IDLE and PRESS_WAIT.
REQ-026 SHALL register all outputs; no combinational path from sw_raw or stop_raw to any output.

Reset
REQ-027 SHALL, on reset, clear sync flops, candidates, counters, inport_ext_input, sw_changed, stop and stop_pulse to 0, and set FSM to IDLE.
REQ-028 SHALL give reset priority over all other updates, including mid-qualification and in HELD; stop and stop_pulse are 0 the cycle after.
REQ-029 SHALL, after reset release with sw_raw already nonzero, qualify it as a normal change, with sw_changed pulsing once.

Structure
REQ-030 SHALL put stop FSM state encodings (2-bit) and default DEBOUNCE_CYCLES in the shared package/header.
REQ-031 SHALL implement the two-flop synchronizer as sub-module sync_2ff, parameterized by width, instantiated for the switch bus (REG_SIZE) and stop (1).

Verification (DEBOUNCE_CYCLES=4)
REQ-032 SHALL cover: reset, then sw_raw 0->0x000000A5 held -> inport_ext_input=0x000000A5 after 7th edge, one sw_changed pulse.
REQ-033 SHALL cover: sw_raw 0x00 -> 0x01 for 3 cycles -> back to 0x00 -> output stays 0x00, no sw_changed.
REQ-034 SHALL cover: stop_raw high 10 cycles -> stop rises after 7th edge, one stop_pulse; low 10 cycles -> stop falls, no pulse.
REQ-035 SHALL cover: stop_raw bounce 1,0,1,0 on single cycles -> FSM oscillates IDLE/PRESS_WAIT, stop stays 0.
REQ-036 SHALL cover: reset asserted one cycle while in HELD with sw qualifying 0x0F -> all outputs 0 next cycle; 0x0F re-qualifies after release.
REQ-037 SHALL cover: sw_raw set to the current output value after a glitch -> no sw_changed pulse.
